// File: rtl/nios2_system_pio_ext.sv
// Parametrised Avalon-MM GPIO slave: output data register with atomic
// set/clear, per-bit direction, two-flop input synchroniser, edge capture
// with interrupt mask, and an edge- or level-sensitive interrupt request.
module nios2_system_pio_ext #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [WIDTH-1:0] DIR_RESET   = '0,
  parameter int               EDGE_TYPE   = 0,
  parameter int               IRQ_TYPE    = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe,
  output logic             irq
);

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_DIR    = 3'd1;
  localparam logic [2:0] ADDR_MASK   = 3'd2;
  localparam logic [2:0] ADDR_EDGE   = 3'd3;
  localparam logic [2:0] ADDR_OUTSET = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR = 3'd5;

  logic             wr_en;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] dir;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecapture;
  logic [WIDTH-1:0] edge_clr;
  logic [WIDTH-1:0] edge_evt;
  logic [WIDTH-1:0] sync_p0;
  logic [WIDTH-1:0] sync_p1;
  logic [WIDTH-1:0] sync_p2;
  logic [WIDTH-1:0] rd_w;

  assign wr_en    = chipselect & ~write_n;
  assign wd       = writedata[WIDTH-1:0];
  assign edge_clr = (wr_en && address == ADDR_EDGE) ? wd : '0;

  // Output data register: plain write, atomic OR-set and AND-NOT-clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out <= RESET_VALUE;
    end else if (wr_en) begin
      case (address)
        ADDR_DATA:   data_out <= wd;
        ADDR_OUTSET: data_out <= data_out | wd;
        ADDR_OUTCLR: data_out <= data_out & ~wd;
        default:     data_out <= data_out;
      endcase
    end
  end

  // Direction and interrupt mask registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dir     <= DIR_RESET;
      irqmask <= '0;
    end else if (wr_en) begin
      if (address == ADDR_DIR)  dir     <= wd;
      if (address == ADDR_MASK) irqmask <= wd;
    end
  end

  // Input path: p0/p1 synchronise the pins, p2 is the one-cycle delay for edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      sync_p2 <= '0;
    end else begin
      sync_p0 <= in_port;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
    end
  end

  // Per-bit edge event selected by the captured edge type.
  always_comb begin
    edge_evt = '0;
    case (EDGE_TYPE)
      0:       edge_evt = sync_p1 & ~sync_p2;
      1:       edge_evt = ~sync_p1 & sync_p2;
      default: edge_evt = sync_p1 ^ sync_p2;
    endcase
  end

  // Sticky edge capture; a new event outranks a same-cycle write-1-clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      edgecapture <= '0;
    end else begin
      edgecapture <= (edgecapture & ~edge_clr) | edge_evt;
    end
  end

  // Zero-wait-state read mux; independent of chipselect.
  always_comb begin
    rd_w = '0;
    case (address)
      ADDR_DATA: rd_w = (dir & data_out) | (~dir & sync_p1);
      ADDR_DIR:  rd_w = dir;
      ADDR_MASK: rd_w = irqmask;
      ADDR_EDGE: rd_w = edgecapture;
      default:   rd_w = '0;
    endcase
  end

  assign readdata = 32'(rd_w);
  assign out_port = data_out;
  assign oe       = dir;

  // Interrupt request: from captured edges or from live synchronised inputs.
  always_comb begin
    irq = 1'b0;
    if (IRQ_TYPE == 1) irq = |(sync_p1 & irqmask & ~dir);
    else               irq = |(edgecapture & irqmask);
  end

endmodule

// File: tb/tb_nios2_system_pio_ext.sv
// Directed bench for nios2_system_pio_ext: instance A uses edge IRQ with
// non-zero reset values, instance B uses level IRQ with default resets.
module tb_nios2_system_pio_ext;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  address = '0;
  logic        cs_a = 1'b0;
  logic        cs_b = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] rd_a, rd_b;
  logic [7:0]  in_a = '0;
  logic [7:0]  in_b = '0;
  logic [7:0]  out_a, out_b, oe_a, oe_b;
  logic        irq_a, irq_b;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  nios2_system_pio_ext #(
    .WIDTH(8), .RESET_VALUE(8'hA5), .DIR_RESET(8'hFF), .EDGE_TYPE(0), .IRQ_TYPE(0)
  ) dut_a (
    .clk(clk), .reset(reset), .address(address), .chipselect(cs_a),
    .write_n(write_n), .writedata(writedata), .readdata(rd_a),
    .in_port(in_a), .out_port(out_a), .oe(oe_a), .irq(irq_a)
  );

  nios2_system_pio_ext #(
    .WIDTH(8), .RESET_VALUE(8'h00), .DIR_RESET(8'h00), .EDGE_TYPE(0), .IRQ_TYPE(1)
  ) dut_b (
    .clk(clk), .reset(reset), .address(address), .chipselect(cs_b),
    .write_n(write_n), .writedata(writedata), .readdata(rd_b),
    .in_port(in_b), .out_port(out_b), .oe(oe_b), .irq(irq_b)
  );

  task automatic bus_write(input bit to_b, input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address   = a;
    writedata = d;
    write_n   = 1'b0;
    cs_a      = ~to_b;
    cs_b      = to_b;
    @(posedge clk);
    #1;
    write_n = 1'b1;
    cs_a    = 1'b0;
    cs_b    = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    address = 3'd0;
    #1;
    total++; if (out_a !== 8'hA5) $display("FAIL reset_out_port got %h want a5", out_a); else passed++;
    total++; if (oe_a !== 8'hFF) $display("FAIL reset_oe got %h want ff", oe_a); else passed++;
    total++; if (irq_a !== 1'b0) $display("FAIL reset_irq got %b want 0", irq_a); else passed++;
    total++; if (rd_a !== 32'h000000A5) $display("FAIL reset_read_data got %h want 000000a5", rd_a); else passed++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_set_clear;
    bus_write(0, 3'd0, 32'h0000003C);
    total++; if (out_a !== 8'h3C) $display("FAIL data_write got %h want 3c", out_a); else passed++;
    bus_write(0, 3'd4, 32'h00000081);
    total++; if (out_a !== 8'hBD) $display("FAIL outset got %h want bd", out_a); else passed++;
    bus_write(0, 3'd5, 32'h0000000C);
    total++; if (out_a !== 8'hB1) $display("FAIL outclear got %h want b1", out_a); else passed++;
    #1;
    total++; if (rd_a !== 32'h0) $display("FAIL outclear_read got %h want 0", rd_a); else passed++;
    address = 3'd4;
    #1;
    total++; if (rd_a !== 32'h0) $display("FAIL outset_read got %h want 0", rd_a); else passed++;
  endtask

  task automatic test_direction;
    bus_write(0, 3'd1, 32'h0000000F);
    bus_write(0, 3'd0, 32'h00000005);
    @(negedge clk);
    in_a = 8'hA0;
    repeat (3) @(posedge clk);
    #1;
    address = 3'd0;
    #1;
    total++; if (rd_a !== 32'h000000A5) $display("FAIL mixed_dir_read got %h want 000000a5", rd_a); else passed++;
    total++; if (out_a !== 8'h05) $display("FAIL out_port_independent got %h want 05", out_a); else passed++;
    bus_write(0, 3'd1, 32'hFFFFFFFF);
    #1;
    total++; if (rd_a !== 32'h000000FF) $display("FAIL dir_upper_bits got %h want 000000ff", rd_a); else passed++;
    bus_write(0, 3'd1, 32'h12345600);
    #1;
    total++; if (rd_a !== 32'h0) $display("FAIL dir_low_byte got %h want 0", rd_a); else passed++;
    total++; if (oe_a !== 8'h00) $display("FAIL oe_follows_dir got %h want 00", oe_a); else passed++;
    address = 3'd0;
    #1;
    total++; if (rd_a !== 32'h000000A0) $display("FAIL input_read got %h want 000000a0", rd_a); else passed++;
    address = 3'd6;
    #1;
    total++; if (rd_a !== 32'h0) $display("FAIL addr6_read got %h want 0", rd_a); else passed++;
  endtask

  task automatic test_edge_capture;
    bus_write(0, 3'd3, 32'h000000FF);
    bus_write(0, 3'd2, 32'h00000001);
    address = 3'd3;
    #1;
    total++; if (rd_a !== 32'h0) $display("FAIL edge_cleared got %h want 0", rd_a); else passed++;
    @(negedge clk);
    in_a = 8'hA1;
    @(posedge clk);
    @(posedge clk);
    #1;
    total++; if (rd_a !== 32'h0) $display("FAIL edge_early got %h want 0", rd_a); else passed++;
    @(posedge clk);
    #1;
    total++; if (rd_a !== 32'h1) $display("FAIL edge_t3 got %h want 1", rd_a); else passed++;
    total++; if (irq_a !== 1'b1) $display("FAIL edge_irq got %b want 1", irq_a); else passed++;
    bus_write(0, 3'd3, 32'h00000001);
    #1;
    total++; if (irq_a !== 1'b0) $display("FAIL w1c_irq got %b want 0", irq_a); else passed++;
    total++; if (rd_a !== 32'h0) $display("FAIL w1c_edge got %h want 0", rd_a); else passed++;
    @(negedge clk);
    in_a = 8'hA0;
    repeat (4) @(posedge clk);
    #1;
    total++; if (rd_a !== 32'h0) $display("FAIL falling_ignored got %h want 0", rd_a); else passed++;
    total++; if (irq_a !== 1'b0) $display("FAIL falling_irq got %b want 0", irq_a); else passed++;
  endtask

  task automatic test_set_wins;
    @(negedge clk);
    in_a = 8'hA1;
    @(posedge clk);
    @(posedge clk);
    bus_write(0, 3'd3, 32'h00000001);
    #1;
    total++; if (rd_a !== 32'h1) $display("FAIL set_wins_edge got %h want 1", rd_a); else passed++;
    total++; if (irq_a !== 1'b1) $display("FAIL set_wins_irq got %b want 1", irq_a); else passed++;
    bus_write(0, 3'd3, 32'h00000001);
    #1;
    total++; if (rd_a !== 32'h0) $display("FAIL later_clear got %h want 0", rd_a); else passed++;
  endtask

  task automatic test_level_irq_and_reset;
    bus_write(1, 3'd2, 32'h00000002);
    address = 3'd3;
    @(negedge clk);
    in_b = 8'h02;
    @(posedge clk);
    #1;
    total++; if (irq_b !== 1'b0) $display("FAIL level_irq_1clk got %b want 0", irq_b); else passed++;
    @(posedge clk);
    #1;
    total++; if (irq_b !== 1'b1) $display("FAIL level_irq_2clk got %b want 1", irq_b); else passed++;
    @(posedge clk);
    #1;
    total++; if (rd_b !== 32'h2) $display("FAIL level_edgecap got %h want 2", rd_b); else passed++;
    @(negedge clk);
    in_b = 8'h00;
    @(posedge clk);
    @(posedge clk);
    #1;
    total++; if (irq_b !== 1'b0) $display("FAIL level_irq_drop got %b want 0", irq_b); else passed++;
    @(negedge clk);
    in_b = 8'h02;
    @(posedge clk);
    @(posedge clk);
    #1;
    total++; if (irq_b !== 1'b1) $display("FAIL level_irq_again got %b want 1", irq_b); else passed++;
    @(negedge clk);
    reset = 1'b1;
    #1;
    total++; if (irq_b !== 1'b0) $display("FAIL async_reset_irq got %b want 0", irq_b); else passed++;
    total++; if (rd_b !== 32'h0) $display("FAIL async_reset_edge got %h want 0", rd_b); else passed++;
    total++; if (out_a !== 8'hA5) $display("FAIL async_reset_out_a got %h want a5", out_a); else passed++;
    total++; if (oe_a !== 8'hFF) $display("FAIL async_reset_oe_a got %h want ff", oe_a); else passed++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    total++; if (rd_b !== 32'h0) $display("FAIL release_early got %h want 0", rd_b); else passed++;
    @(posedge clk);
    #1;
    total++; if (rd_b !== 32'h2) $display("FAIL release_held_high got %h want 2", rd_b); else passed++;
    total++; if (irq_b !== 1'b0) $display("FAIL release_mask_cleared got %b want 0", irq_b); else passed++;
  endtask

  initial begin
    test_reset();
    test_set_clear();
    test_direction();
    test_edge_capture();
    test_set_wins();
    test_level_irq_and_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
